// File: rtl/aes_pkg.sv
// Shared definitions for the AES host command sequencer.
// Register map, field bit positions, word counts and FSM state encoding.
package aes_pkg;

    localparam logic [3:0] ADDR_CONFIG = 4'd1;
    localparam logic [3:0] ADDR_KEY    = 4'd2;
    localparam logic [3:0] ADDR_BLOCK  = 4'd3;
    localparam logic [3:0] ADDR_STATUS = 4'd5;
    localparam logic [3:0] ADDR_START  = 4'd6;
    localparam logic [3:0] ADDR_RESULT = 4'd7;

    localparam int CONFIG_ENCDEC_BIT = 0;
    localparam int CONFIG_KEYLEN_BIT = 1;
    localparam int STATUS_VALID_BIT  = 1;
    localparam int START_INIT_BIT    = 0;
    localparam int START_NEXT_BIT    = 1;

    localparam int KEY128_WORDS = 8;
    localparam int KEY256_WORDS = 16;
    localparam int BLOCK_WORDS  = 8;
    localparam int RESULT_BYTES = 16;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CFG,
        S_KEY,
        S_BLK,
        S_INIT,
        S_NEXT,
        S_POLL,
        S_READ,
        S_DONE
    } seq_state_e;

    function automatic logic [15:0] bit16(input int pos);
        return 16'(1) << pos;
    endfunction

endpackage

// File: rtl/aes_seq_rdpipe.sv
// Read-latency pipeline for the AES register port.
// Tracks issued reads RD_LAT cycles and shifts RESULT bytes into a 128-bit register.
module aes_seq_rdpipe #(
    parameter int RD_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         issue,
    input  logic         issue_res,
    input  logic [7:0]   rd_data,
    output logic         smp_valid,
    output logic         smp_res,
    output logic [127:0] shreg
);

    logic [RD_LAT:0] vld;
    logic [RD_LAT:0] res;

    // Stage 0 lines up with the registered address; stage RD_LAT with valid read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld   <= '0;
            res   <= '0;
            shreg <= '0;
        end else if (clr) begin
            vld   <= '0;
            res   <= '0;
            shreg <= '0;
        end else begin
            vld <= {vld[RD_LAT-1:0], issue};
            res <= {res[RD_LAT-1:0], issue_res};
            if (vld[RD_LAT] && res[RD_LAT]) begin
                shreg <= {shreg[119:0], rd_data};
            end
        end
    end

    assign smp_valid = vld[RD_LAT];
    assign smp_res   = res[RD_LAT];

endmodule

// File: rtl/aes_host_seq.sv
// Command sequencer driving the AES narrow register port from one wide request.
// Optional STATUS-poll timeout is enabled by defining AES_SEQ_TIMEOUT_EN.
module aes_host_seq
    import aes_pkg::*;
#(
    parameter int INIT_WAIT      = 16,
    parameter int RD_LAT         = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_encdec,
    input  logic         req_keylen,
    input  logic         req_new_key,
    input  logic [255:0] req_key,
    input  logic [127:0] req_block,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [127:0] res_data,
    output logic         res_err,
    output logic [3:0]   aes_address,
    output logic [15:0]  aes_data_in,
    input  logic [7:0]   aes_data_out
);

`ifdef AES_SEQ_TIMEOUT_EN
    localparam int WAIT_MAX = (INIT_WAIT > TIMEOUT_CYCLES) ? INIT_WAIT : TIMEOUT_CYCLES;
`else
    localparam int WAIT_MAX = INIT_WAIT;
`endif
    localparam int WW = $clog2(WAIT_MAX + 1);

    seq_state_e     state, state_d;
    logic [4:0]     cnt, cnt_d;
    logic [WW-1:0]  wcnt, wcnt_d;
    logic           keylen_q, new_key_q;
    logic [255:0]   key_q;
    logic [127:0]   block_q;
    logic [3:0]     addr_d;
    logic [15:0]    din_d;
    logic           issue, issue_res;
    logic           smp_valid, smp_res;
    logic           accept;
    logic [4:0]     key_last;
    logic           status_ok;
`ifdef AES_SEQ_TIMEOUT_EN
    logic           err_set;
    logic           err_q;
`endif

    assign accept    = req_valid && req_ready;
    assign req_ready = (state == S_IDLE);
    assign res_valid = (state == S_DONE);
    assign key_last  = keylen_q ? 5'(KEY256_WORDS - 1) : 5'(KEY128_WORDS - 1);
    assign status_ok = smp_valid && !smp_res && aes_data_out[STATUS_VALID_BIT];

    // State, per-state cycle counter and wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            wcnt  <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            wcnt  <= wcnt_d;
        end
    end

    // Next-state logic; both counters restart whenever the state changes.
    always_comb begin
        state_d = state;
        cnt_d   = cnt + 5'd1;
        wcnt_d  = wcnt;
`ifdef AES_SEQ_TIMEOUT_EN
        err_set = 1'b0;
`endif
        unique case (state)
            S_IDLE: begin
                if (accept) state_d = S_CFG;
            end
            S_CFG: begin
                state_d = new_key_q ? S_KEY : S_BLK;
            end
            S_KEY: begin
                if (cnt == key_last) state_d = S_BLK;
            end
            S_BLK: begin
                if (cnt == 5'(BLOCK_WORDS - 1)) begin
                    state_d = new_key_q ? S_INIT : S_NEXT;
                end
            end
            S_INIT: begin
                if (cnt >= 5'd2) begin
                    cnt_d  = cnt;
                    wcnt_d = wcnt + WW'(1);
                    if (wcnt == WW'(INIT_WAIT - 1)) state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (cnt == 5'd1) state_d = S_POLL;
            end
            S_POLL: begin
                cnt_d = cnt;
                if (status_ok) begin
                    state_d = S_READ;
                end
`ifdef AES_SEQ_TIMEOUT_EN
                else begin
                    wcnt_d = wcnt + WW'(1);
                    if (wcnt == WW'(TIMEOUT_CYCLES - 1)) begin
                        state_d = S_DONE;
                        err_set = 1'b1;
                    end
                end
`endif
            end
            S_READ: begin
                if (cnt == 5'(RESULT_BYTES - 1 + RD_LAT)) state_d = S_DONE;
            end
            S_DONE: begin
                cnt_d = cnt;
                if (res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d != state) begin
            cnt_d  = '0;
            wcnt_d = '0;
        end
    end

    // Bus value for the coming cycle, derived from the next state and count.
    always_comb begin
        addr_d    = 4'd0;
        din_d     = 16'd0;
        issue     = 1'b0;
        issue_res = 1'b0;
        unique case (state_d)
            S_CFG: begin
                addr_d = ADDR_CONFIG;
                din_d[CONFIG_ENCDEC_BIT] = req_encdec;
                din_d[CONFIG_KEYLEN_BIT] = req_keylen;
            end
            S_KEY: begin
                addr_d = ADDR_KEY;
                din_d  = key_q[{~cnt_d[3:0], 4'b0000} +: 16];
            end
            S_BLK: begin
                addr_d = ADDR_BLOCK;
                din_d  = block_q[{~cnt_d[2:0], 4'b0000} +: 16];
            end
            S_INIT: begin
                if (cnt_d == 5'd0) begin
                    addr_d = ADDR_START;
                    din_d  = bit16(START_INIT_BIT);
                end else if (cnt_d == 5'd1) begin
                    addr_d = ADDR_START;
                end
            end
            S_NEXT: begin
                addr_d = ADDR_START;
                if (cnt_d == 5'd0) din_d = bit16(START_NEXT_BIT);
            end
            S_POLL: begin
                addr_d = ADDR_STATUS;
                issue  = 1'b1;
            end
            S_READ: begin
                if (cnt_d < 5'(RESULT_BYTES)) begin
                    addr_d    = ADDR_RESULT;
                    issue     = 1'b1;
                    issue_res = 1'b1;
                end
            end
            default: begin
                addr_d = 4'd0;
            end
        endcase
    end

    // Registered AES bus outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aes_address <= 4'd0;
            aes_data_in <= 16'd0;
        end else begin
            aes_address <= addr_d;
            aes_data_in <= din_d;
        end
    end

    // Request fields captured on the accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keylen_q  <= 1'b0;
            new_key_q <= 1'b0;
            key_q     <= '0;
            block_q   <= '0;
        end else if (accept) begin
            keylen_q  <= req_keylen;
            new_key_q <= req_new_key;
            key_q     <= req_key;
            block_q   <= req_block;
        end
    end

`ifdef AES_SEQ_TIMEOUT_EN
    // Timeout flag: set on poll expiry, cleared by the result handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end else if (state == S_DONE && res_ready) begin
            err_q <= 1'b0;
        end
    end
    assign res_err = err_q;
`else
    assign res_err = 1'b0;
`endif

    aes_seq_rdpipe #(
        .RD_LAT(RD_LAT)
    ) u_rdpipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (accept),
        .issue     (issue),
        .issue_res (issue_res),
        .rd_data   (aes_data_out),
        .smp_valid (smp_valid),
        .smp_res   (smp_res),
        .shreg     (res_data)
    );

endmodule
